chan_mux_rr: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It is the next generation of the lab 2:1 gate-level mux. Selection is either round-robin arbitration across requesting channels or a fixed external select. It sits between several producer datapaths and one shared consumer, and registers the chosen beat so downstream timing is isolated.

---
 rtl/chan_mux_pkg.sv | 20 ++
 rtl/chan_mux_rr_arbiter.sv | 36 +++
 rtl/chan_mux_rr.sv | 140 ++++++++++++++
 tb/tb_chan_mux_rr.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_pkg.sv
// Shared types and constants for the registered round-robin channel mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chan_mux_pkg;

  // Packet lock state, used only when CHAN_MUX_LOCK_EN is defined
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Increment a channel index, wrapping n-1 back to 0
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/chan_mux_rr_arbiter.sv
// Wrap-around priority search: first requester at or above ptr, else lowest requester.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_valid,
  output logic [SELW-1:0] grant
);

  logic [SELW-1:0] grant_hi;
  logic [SELW-1:0] grant_lo;
  logic            hi_found;

  // Descending scan leaves the lowest matching index in each candidate
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    hi_found = 1'b0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (req[c]) begin
        grant_lo = SELW'(c);
        if (SELW'(c) >= ptr) begin
          grant_hi = SELW'(c);
          hi_found = 1'b1;
        end
      end
    end
    grant_valid = |req;
    grant       = hi_found ? grant_hi : grant_lo;
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered mux, round-robin or fixed select; optional packet lock via CHAN_MUX_LOCK_EN.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle with out_ready held high.
// Backpressure: in_ready is combinational and only asserts when the output register can load.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
`ifdef CHAN_MUX_LOCK_EN
  input  logic [NCH-1:0]       in_last,
`endif
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] in_arr [NCH];
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  arb_g;
  logic             arb_vld;
  logic [SELW-1:0]  g;
  logic             grant_valid;
  logic             sel_ok;
  logic             load;
  logic             xfer;
  logic             ptr_adv;

  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign in_arr[c] = in_data[c*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req         (in_valid),
    .ptr         (rr_ptr),
    .grant_valid (arb_vld),
    .grant       (arb_g)
  );

  assign sel_ok = (int'(sel) < NCH);
  assign load   = !out_valid || out_ready;
  assign xfer   = load && grant_valid;

`ifdef CHAN_MUX_LOCK_EN
  lock_state_t     state, state_nxt;
  logic [SELW-1:0] lock_ch, lock_nxt;

  // Lock state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_nxt;
    end
  end

  // Enter LOCKED on a non-final beat, leave on the final beat of the locked channel
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_ch;
    case (state)
      ARB: begin
        if (xfer && !in_last[g]) begin
          state_nxt = LOCKED;
          lock_nxt  = g;
        end
      end
      LOCKED: begin
        if (xfer && in_last[lock_ch]) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end
`endif

  // Grant selection: arbiter or fixed select, overridden by an active packet lock
  always_comb begin
    g           = arb_g;
    grant_valid = arb_vld;
    ptr_adv     = (mode == MODE_RR);
    if (mode == MODE_FIXED) begin
      g           = sel;
      grant_valid = sel_ok && in_valid[sel];
    end
`ifdef CHAN_MUX_LOCK_EN
    if (state == LOCKED) begin
      g           = lock_ch;
      grant_valid = in_valid[lock_ch];
      ptr_adv     = in_last[lock_ch];
    end
`endif
  end

  // One-hot accept toward the granted producer; held low during reset
  always_comb begin
    in_ready = '0;
    for (int c = 0; c < NCH; c++) begin
      if (g == SELW'(c)) in_ready[c] = rst_n && xfer;
    end
  end

  // Round-robin pointer moves past each channel it serves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer && ptr_adv) begin
      rr_ptr <= SELW'(wrap_inc(int'(g), NCH));
    end
  end

  // Output register: load replaces or drains; data and sel hold when draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= in_arr[g];
        out_sel  <= g;
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_rr.sv
module tb_chan_mux_rr;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
`ifdef CHAN_MUX_LOCK_EN
  logic [3:0]  in_last;
  logic [4:0]  in_last5;
`endif

  // Second instance with NCH=5 so an out-of-range sel is representable
  logic [2:0]  sel5;
  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_sel5;
  logic        out_valid5;

  int checks = 0;
  int errors = 0;

  chan_mux_rr #(.WIDTH(8), .NCH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef CHAN_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  chan_mux_rr #(.WIDTH(8), .NCH(5)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (1'b1),
    .sel       (sel5),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
`ifdef CHAN_MUX_LOCK_EN
    .in_last   (in_last5),
`endif
    .in_ready  (in_ready5),
    .out_data  (out_data5),
    .out_sel   (out_sel5),
    .out_valid (out_valid5),
    .out_ready (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    sel5      = 3'd5;
    in_data5  = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};
    in_valid5 = 5'b11111;
`ifdef CHAN_MUX_LOCK_EN
    in_last   = 4'b1111;
    in_last5  = 5'b11111;
`endif

    // Reset held: everything idle even with requests present
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'b0000);

    // Release with no requests
    in_valid = 4'b0000;
    rst_n    = 1'b1;
    step();
    check("rel_out_valid", 32'(out_valid), 32'd0);

    // Round-robin fairness, one beat per cycle
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("rr_in_ready0", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_out_valid", 32'(out_valid), 32'd1);
      check("rr_out_sel", 32'(out_sel), 32'(k % 4));
      check("rr_out_data", 32'(out_data), 32'hA0 + 32'(k % 4));
    end

    // Backpressure: no accept, output holds
    out_ready = 1'b0;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'b0000);
    step();
    check("bp_out_data", 32'(out_data), 32'hA0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    // Same-cycle drain and load
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    check("swap_in_ready", 32'(in_ready), 32'b0100);
    step();
    check("swap_out_sel", 32'(out_sel), 32'd2);
    check("swap_out_data", 32'(out_data), 32'hA2);
    check("swap_out_valid", 32'(out_valid), 32'd1);

    // Fixed select, requested channel idle
    mode     = 1'b1;
    sel      = 2'd1;
    in_valid = 4'b1101;
    #1;
    check("fix_nogrant_rdy", 32'(in_ready), 32'b0000);
    step();
    check("fix_drain_valid", 32'(out_valid), 32'd0);
    check("fix_drain_sel", 32'(out_sel), 32'd2);
    in_valid = 4'b1111;
    #1;
    check("fix_in_ready", 32'(in_ready), 32'b0010);
    step();
    check("fix_out_sel", 32'(out_sel), 32'd1);
    check("fix_out_data", 32'(out_data), 32'hA1);

    // Back to round-robin: pointer untouched by the fixed-mode beat (still 3)
    mode = 1'b0;
    #1;
    check("rr_ptr_kept", 32'(in_ready), 32'b1000);
    step();
    check("rr_after_fix", 32'(out_sel), 32'd3);
    in_valid = 4'b0010;
    step();
    check("rr_single", 32'(out_sel), 32'd1);

    // Asynchronous reset between edges while a beat is held
    in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_sel", 32'(out_sel), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'b0000);
    #2;
    rst_n = 1'b1;
    #1;
    check("arst_first_rdy", 32'(in_ready), 32'b0001);
    step();
    check("arst_first_sel", 32'(out_sel), 32'd0);
    check("arst_first_dat", 32'(out_data), 32'hA0);

`ifdef CHAN_MUX_LOCK_EN
    // Channel 1 sends a 3-beat packet while 0 and 2 also request
    in_valid = 4'b0111;
    in_last  = 4'b1101;
    #1;
    check("lock_rdy0", 32'(in_ready), 32'b0010);
    step();
    check("lock_sel0", 32'(out_sel), 32'd1);
    #1;
    check("lock_rdy1", 32'(in_ready), 32'b0010);
    step();
    check("lock_sel1", 32'(out_sel), 32'd1);
    in_last = 4'b1111;
    step();
    check("lock_sel2", 32'(out_sel), 32'd1);
    step();
    check("lock_after", 32'(out_sel), 32'd2);
`endif

    // Out-of-range select on the 5-channel instance
    sel5 = 3'd5;
    #1;
    check("sel5_oor_rdy", 32'(in_ready5), 32'b00000);
    step();
    check("sel5_oor_valid", 32'(out_valid5), 32'd0);
    sel5 = 3'd7;
    #1;
    check("sel7_oor_rdy", 32'(in_ready5), 32'b00000);
    sel5 = 3'd4;
    #1;
    check("sel4_rdy", 32'(in_ready5), 32'b10000);
    step();
    check("sel4_out_sel", 32'(out_sel5), 32'd4);
    check("sel4_out_data", 32'(out_data5), 32'hB4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
